// File: rtl/run_monitor.sv
// run_monitor: end-of-run monitor counting cycles and events, freezing on halt or timeout.
module run_monitor #(
  parameter int CNT_W = 32,
  parameter int N_EVT = 4,
  parameter int RET_W = 16,
  parameter int TIMEOUT = 500000,
  parameter int SIM_REPORT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   halt_i,
  input  logic [RET_W-1:0]       ret_val,
  input  logic [N_EVT-1:0]       evt_i,
  input  logic                   clear_i,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [N_EVT*CNT_W-1:0] evt_count,
  output logic [RET_W-1:0]       ret_latched,
  output logic [1:0]             state,
  output logic                   done
);
  typedef enum logic [1:0] {RUN = 2'b00, HALTED = 2'b01, TMO = 2'b10} state_t;
  localparam logic [63:0] TO = 64'(TIMEOUT);
  state_t st_q, st_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [N_EVT*CNT_W-1:0] evt_q, evt_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic timeout_hit;
  // Compare in 64 bits so a budget wider than the counter simply never fires.
  assign timeout_hit = (TIMEOUT != 0) && (64'(cyc_q) == TO);
  always_comb begin
    st_d = st_q;
    cyc_d = cyc_q;
    evt_d = evt_q;
    ret_d = ret_q;
    if (clear_i) begin
      st_d = RUN;
      cyc_d = '0;
      evt_d = '0;
      ret_d = '0;
    end else if (st_q == RUN) begin
      if (halt_i) begin
        st_d = HALTED;
        ret_d = ret_val;
      end else if (timeout_hit) st_d = TMO;
      else cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
      if (halt_i || !timeout_hit)
        for (int k = 0; k < N_EVT; k++)
          evt_d[k*CNT_W +: CNT_W] = (evt_i[k] && !(&evt_q[k*CNT_W +: CNT_W])) ?
            evt_q[k*CNT_W +: CNT_W] + CNT_W'(1) : evt_q[k*CNT_W +: CNT_W];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= RUN;
      cyc_q <= '0;
      evt_q <= '0;
      ret_q <= '0;
    end else begin
      st_q <= st_d;
      cyc_q <= cyc_d;
      evt_q <= evt_d;
      ret_q <= ret_d;
    end
  end
  assign cycle_count = cyc_q;
  assign evt_count = evt_q;
  assign ret_latched = ret_q;
  assign state = st_q;
  assign done = st_q != RUN;
  if (SIM_REPORT != 0) begin : g_report
    always_ff @(posedge clk) begin
      if (rst_n && !clear_i && st_q == RUN && st_d != RUN) begin
        if (st_d == HALTED) begin
          $display("run_monitor: halted after %0d cycles, ret=%0d", cyc_q, ret_val[7:0]);
          for (int k = 0; k < N_EVT; k++)
            $display("run_monitor:   evt[%0d] = %0d", k, evt_d[k*CNT_W +: CNT_W]);
        end else $display("run_monitor: ran for %0d cycles", TIMEOUT);
        $finish;
      end
    end
  end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: scoreboard bench driving a 32-bit/timeout-20 and a 4-bit/no-timeout monitor in parallel.
module tb_run_monitor;
  logic clk = 0;
  logic rst_n, halt_i, clear_i;
  logic [15:0] ret_val;
  logic [3:0] evt_i;
  logic [31:0] cyc0;
  logic [127:0] ev0;
  logic [15:0] ret0, ret1, ev1;
  logic [1:0] st0, st1;
  logic done0, done1;
  logic [3:0] cyc1;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  run_monitor #(.CNT_W(32), .N_EVT(4), .RET_W(16), .TIMEOUT(20), .SIM_REPORT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .halt_i(halt_i), .ret_val(ret_val), .evt_i(evt_i), .clear_i(clear_i),
    .cycle_count(cyc0), .evt_count(ev0), .ret_latched(ret0), .state(st0), .done(done0));
  run_monitor #(.CNT_W(4), .N_EVT(4), .RET_W(16), .TIMEOUT(0), .SIM_REPORT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .halt_i(halt_i), .ret_val(ret_val), .evt_i(evt_i), .clear_i(clear_i),
    .cycle_count(cyc1), .evt_count(ev1), .ret_latched(ret1), .state(st1), .done(done1));
  // Reference model: mode 0 running, 1 halted, 2 timed out; counts as plain integers.
  longint m_cyc[2], m_ev[2][4], m_max[2] = '{64'hFFFF_FFFF, 15}, m_to[2] = '{20, 0};
  int m_ret[2], m_mode[2];
  typedef struct {
    longint cyc[2];
    longint ev[2][4];
    int ret[2];
    int mode[2];
  } exp_t;
  exp_t q[$];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    else passed++;
  endtask
  function automatic longint bump(longint v, longint mx);
    return v < mx ? v + 1 : mx;
  endfunction
  task automatic step(input logic r, input logic c, input logic h, input logic [3:0] e, input logic [15:0] rv);
    exp_t x;
    @(negedge clk);
    rst_n = r; clear_i = c; halt_i = h; evt_i = e; ret_val = rv;
    for (int d = 0; d < 2; d++) begin
      if (!r || c) begin
        m_cyc[d] = 0; m_ret[d] = 0; m_mode[d] = 0;
        for (int k = 0; k < 4; k++) m_ev[d][k] = 0;
      end else if (m_mode[d] == 0) begin
        if (!h && m_to[d] != 0 && m_cyc[d] == m_to[d]) m_mode[d] = 2;
        else begin
          for (int k = 0; k < 4; k++) if (e[k]) m_ev[d][k] = bump(m_ev[d][k], m_max[d]);
          if (h) begin
            m_mode[d] = 1;
            m_ret[d] = int'(rv);
          end else m_cyc[d] = bump(m_cyc[d], m_max[d]);
        end
      end
    end
    x.cyc = m_cyc; x.ev = m_ev; x.ret = m_ret; x.mode = m_mode;
    q.push_back(x);
    @(posedge clk);
    #3;
  endtask
  task automatic idle(input int n, input logic [3:0] e);
    for (int i = 0; i < n; i++) step(1, 0, 0, e, 16'h0);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("d0_state", 64'(st0), 64'(x.mode[0]));
        chk("d0_done", 64'(done0), 64'(x.mode[0] != 0));
        chk("d0_cycle", 64'(cyc0), 64'(x.cyc[0]));
        chk("d0_ret", 64'(ret0), 64'(x.ret[0]));
        chk("d1_state", 64'(st1), 64'(x.mode[1]));
        chk("d1_done", 64'(done1), 64'(x.mode[1] != 0));
        chk("d1_cycle", 64'(cyc1), 64'(x.cyc[1]));
        chk("d1_ret", 64'(ret1), 64'(x.ret[1]));
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("d0_evt%0d", k), 64'(ev0[k*32 +: 32]), 64'(x.ev[0][k]));
          chk($sformatf("d1_evt%0d", k), 64'(ev1[k*4 +: 4]), 64'(x.ev[1][k]));
        end
      end
    end
  end
  initial begin
    rst_n = 0; clear_i = 0; halt_i = 0; evt_i = 0; ret_val = 0;
    for (int d = 0; d < 2; d++) begin
      m_cyc[d] = 0; m_ret[d] = 0; m_mode[d] = 0;
      for (int k = 0; k < 4; k++) m_ev[d][k] = 0;
    end
    step(0, 0, 0, 4'h0, 16'h0);
    step(0, 0, 0, 4'h0, 16'h0);
    chk("reset_state", 64'(st0), 0);
    chk("reset_done", 64'(done0), 0);
    idle(10, 4'h0);
    step(1, 0, 1, 4'h0, 16'h002A);
    chk("t1_state", 64'(st0), 1);
    chk("t1_cycle", 64'(cyc0), 10);
    chk("t1_ret", 64'(ret0), 16'h2A);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 4'hF, 16'h1234);
    chk("t1_hold_cycle", 64'(cyc0), 10);
    chk("t1_hold_done", 64'(done0), 1);
    step(1, 1, 0, 4'h0, 16'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, {1'b0, i % 2 == 0, 1'b0, 1'b1}, 16'h0);
    step(1, 0, 1, 4'h1, 16'h0007);
    chk("t2_evt0", 64'(ev0[31:0]), 9);
    chk("t2_evt1", 64'(ev0[63:32]), 0);
    chk("t2_evt2", 64'(ev0[95:64]), 4);
    chk("t2_evt3", 64'(ev0[127:96]), 0);
    step(1, 1, 0, 4'hF, 16'h0);
    chk("t5_clear_state", 64'(st0), 0);
    chk("t5_clear_evt0", 64'(ev0[31:0]), 0);
    step(1, 1, 1, 4'hF, 16'h5555);
    chk("t5_clrhalt_state", 64'(st0), 0);
    chk("t5_clrhalt_ret", 64'(ret0), 0);
    idle(20, 4'h0);
    chk("t3_pre_state", 64'(st0), 0);
    step(1, 0, 0, 4'h0, 16'h0);
    chk("t3_timeout_state", 64'(st0), 2);
    chk("t3_timeout_cycle", 64'(cyc0), 20);
    idle(3, 4'hF);
    chk("t3_timeout_hold", 64'(cyc0), 20);
    step(1, 1, 0, 4'h0, 16'h0);
    idle(20, 4'h0);
    step(1, 0, 1, 4'h0, 16'h0099);
    chk("t3_halt_wins", 64'(st0), 1);
    step(1, 1, 0, 4'h0, 16'h0);
    idle(40, 4'h2);
    chk("t4_sat_cycle", 64'(cyc1), 15);
    chk("t4_sat_evt1", 64'(ev1[7:4]), 15);
    step(1, 1, 0, 4'h0, 16'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 4'($urandom), 16'h0);
    step(0, 0, 0, 4'hF, 16'h0);
    chk("t5_rst_cycle", 64'(cyc0), 0);
    chk("t5_rst_evt", 64'(ev0), 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
           4'($urandom), 16'($urandom));
    repeat (2) @(posedge clk);
    #4;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
